// File: rtl/lnrv_exu_brch_rslv.sv
// lnrv_exu_brch_rslv
// Registered branch-resolution unit for the EXU. It evaluates branch
// conditions and redirect targets with its own comparators and adders, and
// checks them against the IFU prediction. It holds one resolved op at a time
// and presents two independent handshakes: a flush/redirect request and a
// link writeback. It also issues a one-cycle BHT training pulse and keeps a
// saturating mispredict counter.
module lnrv_exu_brch_rslv #(
    parameter int XLEN    = 32,
    parameter bit PRED_EN = 1'b1,
    parameter int CNT_W   = 16,
    localparam int BRCH_OP_BUS_WIDTH = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         op_vld,
    output logic                         op_rdy,
    input  logic [BRCH_OP_BUS_WIDTH-1:0] op_bus,
    input  logic [XLEN-1:0]              rs1_rdata,
    input  logic [XLEN-1:0]              rs2_rdata,
    input  logic [XLEN-1:0]              pc,
    input  logic [XLEN-1:0]              imm,
    input  logic                         pred_taken,
    input  logic [XLEN-1:0]              pred_pc,
    input  logic [XLEN-1:0]              dpc,
    input  logic [XLEN-1:0]              mepc,
    output logic                         flush_req,
    input  logic                         flush_ack,
    output logic [XLEN-1:0]              flush_pc,
    output logic                         wbck_vld,
    input  logic                         wbck_rdy,
    output logic [XLEN-1:0]              wbck_data,
    output logic                         cmt_mret,
    output logic                         cmt_dret,
    output logic                         bht_upd_vld,
    output logic [XLEN-1:0]              bht_upd_pc,
    output logic                         bht_upd_taken,
    output logic [CNT_W-1:0]             mispred_cnt
);

    // One-hot positions inside op_bus
    localparam int OP_BEQ   = 0;
    localparam int OP_BNE   = 1;
    localparam int OP_BLT   = 2;
    localparam int OP_BGE   = 3;
    localparam int OP_BLTU  = 4;
    localparam int OP_BGEU  = 5;
    localparam int OP_JAL   = 6;
    localparam int OP_JALR  = 7;
    localparam int OP_MRET  = 8;
    localparam int OP_DRET  = 9;
    localparam int OP_FENCE = 10;

    localparam logic [XLEN-1:0]  PC_INC    = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0]  JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               flush_req_q, flush_req_d;
    logic [XLEN-1:0]    flush_pc_q, flush_pc_d;
    logic               wbck_vld_q, wbck_vld_d;
    logic [XLEN-1:0]    wbck_data_q, wbck_data_d;
    logic               bht_upd_vld_q, bht_upd_vld_d;
    logic [XLEN-1:0]    bht_upd_pc_q, bht_upd_pc_d;
    logic               bht_upd_taken_q, bht_upd_taken_d;
    logic               is_mret_q, is_mret_d;
    logic               is_dret_q, is_dret_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic [XLEN-1:0]    pc_plus4_s;
    logic [XLEN-1:0]    br_tgt_s;
    logic [XLEN-1:0]    jalr_tgt_s;
    logic [XLEN-1:0]    tgt_s;
    logic [XLEN-1:0]    actual_npc_s;
    logic [XLEN-1:0]    pred_npc_s;
    logic               eq_s;
    logic               lt_s;
    logic               ltu_s;
    logic               cond_s;
    logic               is_cond_s;
    logic               is_link_s;
    logic               is_sys_s;
    logic               taken_s;
    logic               npc_miss_s;
    logic               need_flush_s;
    logic               count_miss_s;
    logic               done_s;
    logic               accept_s;

    // Resolve the incoming op: condition, target, actual vs predicted next pc
    always_comb begin
        pc_plus4_s = pc + PC_INC;
        br_tgt_s   = pc + imm;
        jalr_tgt_s = (rs1_rdata + imm) & JALR_MASK;
        eq_s       = (rs1_rdata == rs2_rdata);
        lt_s       = ($signed(rs1_rdata) < $signed(rs2_rdata));
        ltu_s      = (rs1_rdata < rs2_rdata);

        is_cond_s  = |op_bus[OP_BGEU:OP_BEQ];
        is_link_s  = op_bus[OP_JAL] | op_bus[OP_JALR];
        is_sys_s   = op_bus[OP_MRET] | op_bus[OP_DRET] | op_bus[OP_FENCE];

        cond_s = (op_bus[OP_BEQ]  &  eq_s)
               | (op_bus[OP_BNE]  & ~eq_s)
               | (op_bus[OP_BLT]  &  lt_s)
               | (op_bus[OP_BGE]  & ~lt_s)
               | (op_bus[OP_BLTU] &  ltu_s)
               | (op_bus[OP_BGEU] & ~ltu_s);

        taken_s = cond_s | is_link_s | is_sys_s;

        if (op_bus[OP_JALR]) begin
            tgt_s = jalr_tgt_s;
        end else if (op_bus[OP_MRET]) begin
            tgt_s = mepc;
        end else if (op_bus[OP_DRET]) begin
            tgt_s = dpc;
        end else if (op_bus[OP_FENCE]) begin
            tgt_s = pc_plus4_s;
        end else begin
            tgt_s = br_tgt_s;
        end

        actual_npc_s = taken_s ? tgt_s : pc_plus4_s;
        pred_npc_s   = pred_taken ? pred_pc : pc_plus4_s;
        npc_miss_s   = (actual_npc_s != pred_npc_s);

        // Returns and fences always redirect; other ops redirect on a wrong
        // prediction, or on any taken op when prediction is not trusted.
        if (is_sys_s) begin
            need_flush_s = 1'b1;
        end else if (PRED_EN) begin
            need_flush_s = npc_miss_s;
        end else begin
            need_flush_s = taken_s;
        end

        count_miss_s = (is_cond_s | is_link_s) & npc_miss_s;
    end

    // Handshake bookkeeping: the held op is done once every pending request completes
    always_comb begin
        done_s   = (state_q == ST_RESP)
                 & (~flush_req_q | flush_ack)
                 & (~wbck_vld_q  | wbck_rdy);
        op_rdy   = (state_q == ST_IDLE) | done_s;
        accept_s = op_vld & op_rdy;
    end

    // Next-state: capture a new op at accept, otherwise retire handshakes
    always_comb begin
        state_d         = state_q;
        flush_req_d     = flush_req_q & ~flush_ack;
        flush_pc_d      = flush_pc_q;
        wbck_vld_d      = wbck_vld_q & ~wbck_rdy;
        wbck_data_d     = wbck_data_q;
        bht_upd_vld_d   = 1'b0;
        bht_upd_pc_d    = bht_upd_pc_q;
        bht_upd_taken_d = bht_upd_taken_q;
        is_mret_d       = is_mret_q;
        is_dret_d       = is_dret_q;
        mispred_cnt_d   = mispred_cnt_q;

        if (accept_s) begin
            state_d         = ST_RESP;
            flush_req_d     = need_flush_s;
            flush_pc_d      = actual_npc_s;
            wbck_vld_d      = is_link_s;
            wbck_data_d     = pc_plus4_s;
            bht_upd_vld_d   = is_cond_s;
            bht_upd_pc_d    = pc;
            bht_upd_taken_d = cond_s;
            is_mret_d       = op_bus[OP_MRET];
            is_dret_d       = op_bus[OP_DRET];
            if (count_miss_s && (mispred_cnt_q != CNT_MAX)) begin
                mispred_cnt_d = mispred_cnt_q + CNT_ONE;
            end else begin
                mispred_cnt_d = mispred_cnt_q;
            end
        end else if (done_s) begin
            state_d   = ST_IDLE;
            is_mret_d = 1'b0;
            is_dret_d = 1'b0;
        end else begin
            state_d = state_q;
        end
    end

    // State and result registers; reset drops any held op without handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            flush_req_q     <= 1'b0;
            flush_pc_q      <= {XLEN{1'b0}};
            wbck_vld_q      <= 1'b0;
            wbck_data_q     <= {XLEN{1'b0}};
            bht_upd_vld_q   <= 1'b0;
            bht_upd_pc_q    <= {XLEN{1'b0}};
            bht_upd_taken_q <= 1'b0;
            is_mret_q       <= 1'b0;
            is_dret_q       <= 1'b0;
            mispred_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q         <= state_d;
            flush_req_q     <= flush_req_d;
            flush_pc_q      <= flush_pc_d;
            wbck_vld_q      <= wbck_vld_d;
            wbck_data_q     <= wbck_data_d;
            bht_upd_vld_q   <= bht_upd_vld_d;
            bht_upd_pc_q    <= bht_upd_pc_d;
            bht_upd_taken_q <= bht_upd_taken_d;
            is_mret_q       <= is_mret_d;
            is_dret_q       <= is_dret_d;
            mispred_cnt_q   <= mispred_cnt_d;
        end
    end

    // Output drive: registered results, commit pulses qualified by the flush handshake
    always_comb begin
        flush_req     = flush_req_q;
        flush_pc      = flush_pc_q;
        wbck_vld      = wbck_vld_q;
        wbck_data     = wbck_data_q;
        bht_upd_vld   = bht_upd_vld_q;
        bht_upd_pc    = bht_upd_pc_q;
        bht_upd_taken = bht_upd_taken_q;
        mispred_cnt   = mispred_cnt_q;
        cmt_mret      = flush_req_q & flush_ack & is_mret_q;
        cmt_dret      = flush_req_q & flush_ack & is_dret_q;
    end

endmodule

// File: tb/tb_lnrv_exu_brch_rslv.sv
// Self-checking bench for lnrv_exu_brch_rslv: directed cases followed by a
// randomized stream, scored by a queue-based scoreboard and a monitor.
module tb_lnrv_exu_brch_rslv;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_vld = 1'b0;
    logic        op_rdy;
    logic [10:0] op_bus = 11'd0;
    logic [31:0] rs1_rdata = 32'd0, rs2_rdata = 32'd0, pc = 32'd0, imm = 32'd0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_pc = 32'd0, dpc = 32'd0, mepc = 32'd0;
    logic        flush_req, flush_ack = 1'b0;
    logic [31:0] flush_pc;
    logic        wbck_vld, wbck_rdy = 1'b0;
    logic [31:0] wbck_data;
    logic        cmt_mret, cmt_dret;
    logic        bht_upd_vld;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;
    logic [CW-1:0] mispred_cnt;

    lnrv_exu_brch_rslv #(.XLEN(32), .PRED_EN(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op_rdy(op_rdy), .op_bus(op_bus),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .dpc(dpc), .mepc(mepc),
        .flush_req(flush_req), .flush_ack(flush_ack), .flush_pc(flush_pc),
        .wbck_vld(wbck_vld), .wbck_rdy(wbck_rdy), .wbck_data(wbck_data),
        .cmt_mret(cmt_mret), .cmt_dret(cmt_dret),
        .bht_upd_vld(bht_upd_vld), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic [31:0] fpc;
        logic        wb;
        logic [31:0] wd;
        logic        bht;
        logic [31:0] bpc;
        logic        btk;
        logic        mis;
        logic [CW-1:0] cnt;
        logic        mret;
        logic        dret;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en = 1'b0;
    logic rand_ack = 1'b0;
    logic [CW-1:0] mdl_cnt = '0;
    int   cur_k = 0;
    logic last_acc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: op index 0..10 = beq bne blt bge bltu bgeu jal jalr mret dret fence
    function automatic exp_t ref_model(input int k, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] p, input logic [31:0] im,
                                       input logic pt, input logic [31:0] pp,
                                       input logic [31:0] dp, input logic [31:0] mp);
        exp_t e;
        logic tk;
        logic [31:0] tgt, p4, anpc, pnpc;
        p4  = p + 32'd4;
        tk  = 1'b1;
        tgt = p + im;
        case (k)
            0: tk = (a == b);
            1: tk = (a != b);
            2: tk = ($signed(a) < $signed(b));
            3: tk = ($signed(a) >= $signed(b));
            4: tk = (a < b);
            5: tk = (a >= b);
            7: tgt = (a + im) & 32'hFFFF_FFFE;
            8: tgt = mp;
            9: tgt = dp;
            10: tgt = p4;
            default: tgt = p + im;
        endcase
        anpc   = tk ? tgt : p4;
        pnpc   = pt ? pp : p4;
        e.fl   = (k >= 8) ? 1'b1 : (anpc != pnpc);
        e.fpc  = anpc;
        e.wb   = (k == 6) || (k == 7);
        e.wd   = p4;
        e.bht  = (k <= 5);
        e.bpc  = p;
        e.btk  = (k <= 5) ? tk : 1'b0;
        e.mis  = (k <= 7) && (anpc != pnpc);
        e.cnt  = '0;
        e.mret = (k == 8);
        e.dret = (k == 9);
        return e;
    endfunction

    // One clock: note whether the DUT accepts, score the accept, then update acks
    task automatic tick();
        logic acc;
        exp_t e;
        @(negedge clk);
        acc = op_vld && op_rdy;
        @(posedge clk);
        if (acc && mon_en) begin
            e = ref_model(cur_k, rs1_rdata, rs2_rdata, pc, imm, pred_taken, pred_pc, dpc, mepc);
            if (e.mis && mdl_cnt != {CW{1'b1}}) mdl_cnt = mdl_cnt + 1'b1;
            e.cnt = mdl_cnt;
            sb_q.push_back(e);
        end
        last_acc = acc;
        #1;
        if (rand_ack) begin
            flush_ack = 1'($urandom_range(0, 1));
            wbck_rdy  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic pt, input logic [31:0] pp);
        int n;
        cur_k = k;
        op_bus = 11'd1 << k;
        rs1_rdata = a; rs2_rdata = b; pc = p; imm = im;
        pred_taken = pt; pred_pc = pp;
        op_vld = 1'b1;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 64) begin
            tick();
            n++;
        end
        if (!last_acc) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
        end
        op_vld = 1'b0;
        // Scramble held-op inputs: the unit must ignore them after accept
        op_bus = 11'($urandom); rs1_rdata = $urandom; rs2_rdata = $urandom;
        pc = $urandom; imm = $urandom; pred_pc = $urandom;
    endtask

    // Monitor: tracks pending handshakes and compares every cycle at the falling edge
    exp_t cur = '0;
    logic m_busy = 1'b0, m_pf = 1'b0, m_pw = 1'b0, m_new = 1'b0, m_done;
    always @(negedge clk) begin
        if (!mon_en) begin
            m_busy = 1'b0; m_pf = 1'b0; m_pw = 1'b0; m_new = 1'b0;
        end else begin
            if (m_new) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL sb_empty: got response expected none queued");
                end else begin
                    cur = sb_q.pop_front();
                    m_busy = 1'b1; m_pf = cur.fl; m_pw = cur.wb;
                    chk("bht_upd_vld", bht_upd_vld, cur.bht);
                    if (cur.bht) begin
                        chk("bht_upd_pc", bht_upd_pc, cur.bpc);
                        chk("bht_upd_taken", bht_upd_taken, cur.btk);
                    end
                    chk("mispred_cnt", mispred_cnt, cur.cnt);
                end
            end else begin
                chk("bht_upd_idle", bht_upd_vld, 0);
            end
            chk("flush_req", flush_req, m_pf);
            if (m_pf) chk("flush_pc", flush_pc, cur.fpc);
            chk("wbck_vld", wbck_vld, m_pw);
            if (m_pw) chk("wbck_data", wbck_data, cur.wd);
            m_done = m_busy && (!m_pf || flush_ack) && (!m_pw || wbck_rdy);
            chk("op_rdy", op_rdy, !m_busy || m_done);
            chk("cmt_mret", cmt_mret, m_pf && flush_ack && cur.mret);
            chk("cmt_dret", cmt_dret, m_pf && flush_ack && cur.dret);
            if (m_pf && flush_ack) m_pf = 1'b0;
            if (m_pw && wbck_rdy) m_pw = 1'b0;
            if (m_done) m_busy = 1'b0;
            m_new = op_vld && op_rdy;
        end
    end

    task automatic drain();
        rand_ack = 1'b0; flush_ack = 1'b1; wbck_rdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_flush_req", flush_req, 0);
        chk("rst_wbck_vld", wbck_vld, 0);
        chk("rst_bht_vld", bht_upd_vld, 0);
        chk("rst_cnt", mispred_cnt, 0);
        chk("rst_flush_pc", flush_pc, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; mon_en = 1'b1;
        flush_ack = 1'b1; wbck_rdy = 1'b1;

        // bne equal operands: not taken, no flush
        issue(1, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'd0);
        chk("bne_flush", flush_req, 0);
        chk("bne_taken", bht_upd_taken, 0);
        // blt signed taken, mispredicted
        issue(2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0, 32'd0);
        chk("blt_flush_pc", flush_pc, 32'h1F8);
        chk("blt_cnt", mispred_cnt, 1);
        // bltu same operands: not taken
        issue(4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0, 32'd0);
        chk("bltu_flush", flush_req, 0);
        // jalr correctly predicted
        issue(7, 32'h1003, 32'd0, 32'h40, 32'd4, 1'b1, 32'h1006);
        chk("jalr_flush", flush_req, 0);
        chk("jalr_wbck", wbck_data, 32'h44);
        tick();

        // jal: flush acked in first response cycle, writeback held 3 cycles
        flush_ack = 1'b0; wbck_rdy = 1'b0;
        issue(6, 32'd0, 32'd0, 32'h300, 32'h40, 1'b0, 32'd0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        wbck_rdy = 1'b1;
        tick();

        // mret: commit pulse only with flush_ack
        flush_ack = 1'b0;
        mepc = 32'h8000;
        issue(8, 32'd0, 32'd0, 32'h500, 32'd0, 1'b0, 32'd0);
        chk("mret_flush_pc", flush_pc, 32'h8000);
        tick();
        flush_ack = 1'b1;
        tick();
        dpc = 32'h9000;
        issue(9, 32'd0, 32'd0, 32'h600, 32'd0, 1'b0, 32'd0);
        tick();

        // Randomized stream with random handshakes and idle gaps
        rand_ack = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int k;
            logic [31:0] a, b, p, im, pp;
            logic pt;
            k  = $urandom_range(0, 10);
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            b  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                              : 32'($urandom_range(0, 3));
            p  = $urandom & 32'hFFFF_FFFC;
            im = 32'($urandom_range(0, 511)) - 32'd256;
            pt = 1'($urandom_range(0, 1));
            pp = ($urandom_range(0, 1) == 1) ? p + im : $urandom;
            mepc = $urandom; dpc = $urandom;
            issue(k, a, b, p, im, pt, pp);
            if ($urandom_range(0, 3) == 0) tick();
        end

        // Force mispredicts well past the counter range
        for (int i = 0; i < 20; i++)
            issue(2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0, 32'd0);
        drain();
        chk("cnt_saturated", mispred_cnt, {{(32-CW){1'b0}}, {CW{1'b1}}});

        // Reset in the middle of a held jal
        flush_ack = 1'b0; wbck_rdy = 1'b0;
        issue(6, 32'd0, 32'd0, 32'h700, 32'h80, 1'b0, 32'd0);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flush_req", flush_req, 0);
        chk("mid_rst_wbck_vld", wbck_vld, 0);
        chk("mid_rst_bht_vld", bht_upd_vld, 0);
        chk("mid_rst_cnt", mispred_cnt, 0);
        chk("mid_rst_flush_pc", flush_pc, 0);
        sb_q.delete();
        mdl_cnt = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; mon_en = 1'b1;

        rand_ack = 1'b1;
        for (int i = 0; i < 30; i++)
            issue($urandom_range(0, 10), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
                  32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom);
        drain();
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
